// File: rtl/writeback_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// writeback_buffer : queues evicted dirty lines, drains them one at a time to
//                    store_data, and offers a combinational line lookup.
//                    Optional macro WB_COALESCE_EN merges pushes into queued lines.
// Revision 1.0
// ---------------------------------------------------------------------------
module writeback_buffer #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int LINE_WIDTH     = 512,
  parameter int OFFSET_BITS    = 6,
  parameter int DEPTH          = 4,
  parameter int PTR_WIDTH      = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      evict_valid,
  input  logic [BUS_DATA_WIDTH-1:0] evict_addr,
  input  logic [LINE_WIDTH-1:0]     evict_data,
  output logic                      evict_ready,
  input  logic [BUS_DATA_WIDTH-1:0] lookup_addr,
  output logic                      lookup_hit,
  output logic [LINE_WIDTH-1:0]     lookup_data,
  output logic                      wd_enable,
  output logic [BUS_DATA_WIDTH-1:0] wd_addr,
  output logic [LINE_WIDTH-1:0]     wd_data,
  input  logic                      wd_ready,
  output logic                      empty,
  output logic [PTR_WIDTH:0]        count
);

  localparam int                 TAG_W   = BUS_DATA_WIDTH - OFFSET_BITS;
  localparam logic [PTR_WIDTH:0] C_DEPTH = (PTR_WIDTH+1)'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [DEPTH-1:0]      r_valid;
  logic [TAG_W-1:0]      r_tag  [DEPTH];
  logic [LINE_WIDTH-1:0] r_data [DEPTH];
  logic [PTR_WIDTH-1:0]  r_rd_ptr;
  logic [PTR_WIDTH-1:0]  r_wr_ptr;
  logic [PTR_WIDTH:0]    r_count;
  logic [1:0]            r_state;
  logic                  r_seen_busy;

  logic [TAG_W-1:0]      w_evict_tag;
  logic [TAG_W-1:0]      w_lookup_tag;
  logic                  w_push;
  logic                  w_alloc;
  logic                  w_merge;
  logic [PTR_WIDTH-1:0]  w_co_idx;
  logic                  w_done;
  logic                  w_pop;
  logic                  w_lk_hit;
  logic [PTR_WIDTH-1:0]  w_lk_idx;
  logic [PTR_WIDTH-1:0]  w_lk_ord;
  logic                  w_unused;

  assign w_evict_tag  = evict_addr[BUS_DATA_WIDTH-1:OFFSET_BITS];
  assign w_lookup_tag = lookup_addr[BUS_DATA_WIDTH-1:OFFSET_BITS];
  assign w_unused     = ^{evict_addr[OFFSET_BITS-1:0], lookup_addr[OFFSET_BITS-1:0]};

  // Walk entries oldest to youngest so the last match is the youngest one.
  always_comb begin
    w_lk_hit = 1'b0;
    w_lk_idx = r_rd_ptr;
    w_lk_ord = r_rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      w_lk_ord = r_rd_ptr + PTR_WIDTH'(i);
      if (r_valid[w_lk_ord] && (r_tag[w_lk_ord] == w_lookup_tag)) begin
        w_lk_hit = 1'b1;
        w_lk_idx = w_lk_ord;
      end
    end
  end

  assign lookup_hit  = !reset && w_lk_hit;
  assign lookup_data = lookup_hit ? r_data[w_lk_idx] : '0;

`ifdef WB_COALESCE_EN
  logic                 w_co_hit;
  logic [PTR_WIDTH-1:0] w_co_ord;

  // The head is only mergeable before the drain engine has started on it.
  always_comb begin
    w_co_hit = 1'b0;
    w_co_idx = r_rd_ptr;
    w_co_ord = r_rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      w_co_ord = r_rd_ptr + PTR_WIDTH'(i);
      if (r_valid[w_co_ord] && (r_tag[w_co_ord] == w_evict_tag) &&
          ((w_co_ord != r_rd_ptr) || (r_state == S_IDLE))) begin
        w_co_hit = 1'b1;
        w_co_idx = w_co_ord;
      end
    end
  end

  assign evict_ready = !reset && ((r_count < C_DEPTH) || w_co_hit);
  assign w_push      = evict_valid && evict_ready;
  assign w_alloc     = w_push && !w_co_hit;
  assign w_merge     = w_push && w_co_hit;
`else
  assign evict_ready = !reset && (r_count < C_DEPTH);
  assign w_push      = evict_valid && evict_ready;
  assign w_alloc     = w_push;
  assign w_merge     = 1'b0;
  assign w_co_idx    = '0;
`endif

  // A ready left high by the previous transfer must be seen low first.
  assign w_done = (r_state == S_WAIT) && r_seen_busy && wd_ready;
  assign w_pop  = w_done;

  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_tag[r_wr_ptr]  <= w_evict_tag;
      r_data[r_wr_ptr] <= evict_data;
    end else if (w_merge) begin
      r_data[w_co_idx] <= evict_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid     <= '0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_state     <= S_IDLE;
      r_seen_busy <= 1'b0;
    end else begin
      if (w_alloc) begin
        r_valid[r_wr_ptr] <= 1'b1;
        r_wr_ptr          <= r_wr_ptr + PTR_WIDTH'(1);
      end
      if (w_pop) begin
        r_valid[r_rd_ptr] <= 1'b0;
        r_rd_ptr          <= r_rd_ptr + PTR_WIDTH'(1);
      end
      r_count <= r_count + {{PTR_WIDTH{1'b0}}, w_alloc} - {{PTR_WIDTH{1'b0}}, w_pop};

      case (r_state)
        S_IDLE: begin
          if (r_count != '0) r_state <= S_ISSUE;
        end
        S_ISSUE: begin
          r_seen_busy <= 1'b0;
          r_state     <= S_WAIT;
        end
        S_WAIT: begin
          if (!wd_ready) r_seen_busy <= 1'b1;
          if (w_done)    r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign wd_enable = !reset && (r_state == S_ISSUE);
  assign wd_addr   = {r_tag[r_rd_ptr], {OFFSET_BITS{1'b0}}};
  assign wd_data   = r_data[r_rd_ptr];
  assign empty     = reset || ((r_count == '0) && (r_state == S_IDLE));
  assign count     = r_count;

endmodule
`default_nettype wire
